// File: rtl/lsu.sv
// Load/store unit: passes ALU results through, runs single-beat bus loads/stores.
// Optional LSU_MISALIGN_CHECK_EN rejects misaligned half/word accesses without a bus cycle.
module lsu #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  e_valid,
    output logic                  e_ready,
    input  logic                  e_regW,
    input  logic [ADDR_WIDTH-1:0] e_regAddr,
    input  logic [DATA_WIDTH-1:0] e_regData,
    input  logic                  e_memRd,
    input  logic                  e_memWr,
    input  logic [1:0]            e_memSize,
    input  logic                  e_memUnsigned,
    input  logic [DATA_WIDTH-1:0] e_storeData,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wmask,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_regW,
    output logic [ADDR_WIDTH-1:0] m_regAddr,
    output logic [DATA_WIDTH-1:0] m_regData,
    output logic                  m_misalign
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                  state_q, state_d;
    logic                    m_valid_q, m_valid_d;
    logic                    m_reg_w_q, m_reg_w_d;
    logic [ADDR_WIDTH-1:0]   m_reg_addr_q, m_reg_addr_d;
    logic [DATA_WIDTH-1:0]   m_reg_data_q, m_reg_data_d;
    logic                    m_misalign_q, m_misalign_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [31:0]             mem_addr_q, mem_addr_d;
    logic [31:0]             mem_wdata_q, mem_wdata_d;
    logic [3:0]              mem_wmask_q, mem_wmask_d;
    logic                    ld_reg_w_q, ld_reg_w_d;
    logic [ADDR_WIDTH-1:0]   ld_reg_addr_q, ld_reg_addr_d;
    logic [1:0]              ld_size_q, ld_size_d;
    logic                    ld_unsigned_q, ld_unsigned_d;
    logic [1:0]              ld_off_q, ld_off_d;

    logic       accept;
    logic       is_mem;
    logic       misalign_hit;
    logic [1:0] off;

    // Misaligned halves fall back to the aligned-down lane pair.
    function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] boff);
        case (size)
            2'b00:   return 4'b0001 << boff;
            2'b01:   return boff[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] size,
                                                 input logic [1:0] boff, input logic uns);
        logic [31:0] b_lanes;
        logic [31:0] h_lanes;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b_lanes = rdata >> {boff, 3'b000};
        h_lanes = rdata >> {boff[1], 4'b0000};
        b = b_lanes[7:0];
        h = h_lanes[15:0];
        case (size)
            2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: return rdata;
        endcase
    endfunction

    assign off     = e_regData[1:0];
    assign is_mem  = e_memRd | e_memWr;
    assign e_ready = (state_q == IDLE) && (!m_valid_q || m_ready);
    assign accept  = e_valid && e_ready;

`ifdef LSU_MISALIGN_CHECK_EN
    assign misalign_hit = is_mem && (((e_memSize == 2'b01) && off[0]) ||
                                     (e_memSize[1] && (off != 2'b00)));
`else
    assign misalign_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        m_valid_d     = m_valid_q;
        m_reg_w_d     = m_reg_w_q;
        m_reg_addr_d  = m_reg_addr_q;
        m_reg_data_d  = m_reg_data_q;
        m_misalign_d  = m_misalign_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wmask_d   = mem_wmask_q;
        ld_reg_w_d    = ld_reg_w_q;
        ld_reg_addr_d = ld_reg_addr_q;
        ld_size_d     = ld_size_q;
        ld_unsigned_d = ld_unsigned_q;
        ld_off_d      = ld_off_q;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!is_mem || misalign_hit) begin
                        m_valid_d    = 1'b1;
                        m_reg_w_d    = !is_mem && e_regW && (e_regAddr != '0);
                        m_reg_addr_d = e_regAddr;
                        m_reg_data_d = is_mem ? '0 : e_regData;
                        m_misalign_d = misalign_hit;
                    end else begin
                        state_d       = REQ;
                        mem_req_d     = 1'b1;
                        mem_we_d      = e_memWr;
                        mem_addr_d    = {e_regData[31:2], 2'b00};
                        mem_wdata_d   = e_memWr ? store_data(e_memSize, e_storeData) : '0;
                        mem_wmask_d   = e_memWr ? store_mask(e_memSize, off) : 4'b0000;
                        ld_reg_w_d    = e_regW;
                        ld_reg_addr_d = e_regAddr;
                        ld_size_d     = e_memSize;
                        ld_unsigned_d = e_memUnsigned;
                        ld_off_d      = off;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (mem_we_q) begin
                        state_d      = IDLE;
                        m_valid_d    = 1'b1;
                        m_reg_w_d    = 1'b0;
                        m_reg_addr_d = ld_reg_addr_q;
                        m_reg_data_d = '0;
                        m_misalign_d = 1'b0;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d      = IDLE;
                    m_valid_d    = 1'b1;
                    m_reg_w_d    = ld_reg_w_q && (ld_reg_addr_q != '0);
                    m_reg_addr_d = ld_reg_addr_q;
                    m_reg_data_d = load_extract(mem_rdata, ld_size_q, ld_off_q, ld_unsigned_q);
                    m_misalign_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            m_valid_q    <= 1'b0;
            m_reg_w_q    <= 1'b0;
            m_reg_addr_q <= '0;
            m_reg_data_q <= '0;
            m_misalign_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= '0;
        end else begin
            state_q      <= state_d;
            m_valid_q    <= m_valid_d;
            m_reg_w_q    <= m_reg_w_d;
            m_reg_addr_q <= m_reg_addr_d;
            m_reg_data_q <= m_reg_data_d;
            m_misalign_q <= m_misalign_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wmask_q  <= mem_wmask_d;
        end
    end

    // Pending-load context is only meaningful in REQ/WAIT, so it carries no reset.
    always_ff @(posedge clk) begin
        ld_reg_w_q    <= ld_reg_w_d;
        ld_reg_addr_q <= ld_reg_addr_d;
        ld_size_q     <= ld_size_d;
        ld_unsigned_q <= ld_unsigned_d;
        ld_off_q      <= ld_off_d;
    end

    assign m_valid    = m_valid_q;
    assign m_regW     = m_reg_w_q;
    assign m_regAddr  = m_reg_addr_q;
    assign m_regData  = m_reg_data_q;
    assign m_misalign = m_misalign_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wmask  = mem_wmask_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: expected-result queue model plus per-cycle output checker.
module tb_lsu;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          e_valid, e_ready, e_regW, e_memRd, e_memWr, e_memUnsigned;
    logic [AW-1:0] e_regAddr;
    logic [DW-1:0] e_regData, e_storeData;
    logic [1:0]    e_memSize;
    logic          mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0]   mem_addr, mem_wdata, mem_rdata;
    logic [3:0]    mem_wmask;
    logic          m_valid, m_ready, m_regW, m_misalign;
    logic [AW-1:0] m_regAddr;
    logic [DW-1:0] m_regData;

    always #5 clk = ~clk;

    lsu #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .e_valid(e_valid), .e_ready(e_ready), .e_regW(e_regW), .e_regAddr(e_regAddr),
        .e_regData(e_regData), .e_memRd(e_memRd), .e_memWr(e_memWr), .e_memSize(e_memSize),
        .e_memUnsigned(e_memUnsigned), .e_storeData(e_storeData),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_regW(m_regW), .m_regAddr(m_regAddr),
        .m_regData(m_regData), .m_misalign(m_misalign)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic          mis;
        logic          chk_d;
    } exp_t;
    exp_t expq[$];

    // Reference load: pick the addressed lane(s) of the word, then extend.
    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                               input logic [1:0] size, input logic uns);
        int unsigned off;
        logic [31:0] v;
        off = addr[1:0];
        case (size)
            2'b00: begin
                v = (rdata >> (8 * off)) & 32'hFF;
                if (!uns && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'b01: begin
                v = (rdata >> (16 * (off / 2))) & 32'hFFFF;
                if (!uns && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = rdata;
        endcase
        return v;
    endfunction

    // Per-cycle checker: pops the model on each write-back handshake, and
    // requires outputs to stay frozen while the consumer stalls.
    exp_t          e_cur;
    logic          hold_prev = 1'b0;
    logic          s_w, s_mis;
    logic [AW-1:0] s_a;
    logic [31:0]   s_d;
    always @(negedge clk) begin
        if (!rst) begin
            if (hold_prev) begin
                chk("hold_m_valid", {31'b0, m_valid}, 32'd1);
                chk("hold_m_regW", {31'b0, m_regW}, {31'b0, s_w});
                chk("hold_m_regAddr", {27'b0, m_regAddr}, {27'b0, s_a});
                chk("hold_m_regData", m_regData, s_d);
                chk("hold_m_misalign", {31'b0, m_misalign}, {31'b0, s_mis});
            end
            if (m_valid && m_ready) begin
                if (expq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_result: got m_valid=1 addr=%0d expected no pending result at %0t",
                             m_regAddr, $time);
                end else begin
                    e_cur = expq.pop_front();
                    chk("res_m_regW", {31'b0, m_regW}, {31'b0, e_cur.w});
                    chk("res_m_regAddr", {27'b0, m_regAddr}, {27'b0, e_cur.a});
                    if (e_cur.chk_d) chk("res_m_regData", m_regData, e_cur.d);
                    chk("res_m_misalign", {31'b0, m_misalign}, {31'b0, e_cur.mis});
                end
            end
        end
        hold_prev = m_valid && !m_ready && !rst;
        s_w = m_regW; s_a = m_regAddr; s_d = m_regData; s_mis = m_misalign;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        e_valid = 1'b0; e_memRd = 1'b0; e_memWr = 1'b0; e_regW = 1'b0;
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic regw, input logic [AW-1:0] ra,
                          input logic [31:0] data, input logic [1:0] sz, input logic uns,
                          input logic [31:0] sdata);
        e_valid = 1'b1; e_memRd = rd; e_memWr = wr; e_regW = regw; e_regAddr = ra;
        e_regData = data; e_memSize = sz; e_memUnsigned = uns; e_storeData = sdata;
    endtask

    task automatic alu_op(input logic [AW-1:0] ra, input logic [31:0] data);
        set_op(1'b0, 1'b0, 1'b1, ra, data, 2'b10, 1'b0, 32'h0);
        expq.push_back('{w: (ra != 0), a: ra, d: data, mis: 1'b0, chk_d: 1'b1});
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] sdata,
                            input logic [3:0] x_mask, input logic [31:0] x_wdata, input int gnt_cyc);
        set_op(1'b0, 1'b1, 1'b1, 5'd5, addr, sz, 1'b0, sdata);
        expq.push_back('{w: 1'b0, a: 5'd5, d: 32'h0, mis: 1'b0, chk_d: 1'b0});
        @(negedge clk); chk("st_e_ready", {31'b0, e_ready}, 32'd1);
        tick(); idle_in();
        for (int i = 1; i <= gnt_cyc; i++) begin
            mem_gnt = (i == gnt_cyc);
            @(negedge clk);
            chk("st_mem_req", {31'b0, mem_req}, 32'd1);
            chk("st_mem_we", {31'b0, mem_we}, 32'd1);
            chk("st_mem_addr", mem_addr, 32'h1000);
            chk("st_mem_wmask", {28'b0, mem_wmask}, {28'b0, x_mask});
            chk("st_mem_wdata", mem_wdata, x_wdata);
            chk("st_no_early_valid", {31'b0, m_valid}, 32'd0);
            tick();
        end
        mem_gnt = 1'b0;
        @(negedge clk);
        chk("st_m_valid", {31'b0, m_valid}, 32'd1);
        chk("st_m_regW", {31'b0, m_regW}, 32'd0);
        chk("st_mem_req_drop", {31'b0, mem_req}, 32'd0);
        tick();
    endtask

    // Grant in the first REQ cycle, with a spurious rvalid alongside it.
    task automatic do_load(input logic [31:0] addr, input logic [1:0] sz, input logic uns,
                           input logic [AW-1:0] ra, input logic [31:0] rdata, input int rv_delay,
                           input logic [31:0] lit);
        set_op(1'b1, 1'b0, 1'b1, ra, addr, sz, uns, 32'h0);
        expq.push_back('{w: (ra != 0), a: ra, d: model_load(rdata, addr, sz, uns), mis: 1'b0, chk_d: 1'b1});
        @(negedge clk); chk("ld_e_ready", {31'b0, e_ready}, 32'd1);
        tick(); idle_in();
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("ld_mem_req", {31'b0, mem_req}, 32'd1);
        chk("ld_mem_we", {31'b0, mem_we}, 32'd0);
        chk("ld_mem_addr", mem_addr, {addr[31:2], 2'b00});
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        for (int i = 1; i < rv_delay; i++) begin
            @(negedge clk); chk("ld_wait_no_valid", {31'b0, m_valid}, 32'd0);
            tick();
        end
        mem_rvalid = 1'b1; mem_rdata = rdata;
        @(negedge clk); chk("ld_pre_rvalid", {31'b0, m_valid}, 32'd0);
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        chk("ld_m_valid", {31'b0, m_valid}, 32'd1);
        chk("ld_m_regData", m_regData, lit);
        tick();
    endtask

    initial begin
        rst = 1'b1; m_ready = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        e_regAddr = '0; e_regData = '0; e_memSize = 2'b00; e_memUnsigned = 1'b0; e_storeData = '0;
        idle_in();
        tick(); tick();
        rst = 1'b0;

        @(negedge clk);
        chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
        chk("rst_e_ready", {31'b0, e_ready}, 32'd1);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_wmask", {28'b0, mem_wmask}, 32'd0);
        chk("rst_m_regW", {31'b0, m_regW}, 32'd0);
        chk("rst_m_regAddr", {27'b0, m_regAddr}, 32'd0);
        chk("rst_m_regData", m_regData, 32'd0);
        chk("rst_m_misalign", {31'b0, m_misalign}, 32'd0);
        tick();

        chk("model_half_s", model_load(32'h8001_0000, 32'h2002, 2'b01, 1'b0), 32'hFFFF_8001);
        chk("model_half_u", model_load(32'h8001_0000, 32'h2002, 2'b01, 1'b1), 32'h0000_8001);
        chk("model_byte_s", model_load(32'h0000_A500, 32'h2001, 2'b00, 1'b0), 32'hFFFF_FFA5);

        // Three back-to-back ALU ops.
        for (int i = 0; i < 3; i++) begin
            alu_op(AW'(i + 1), 32'h11 * (i + 1));
            @(negedge clk);
            chk("b2b_e_ready", {31'b0, e_ready}, 32'd1);
            if (i > 0) begin
                chk("b2b_m_valid", {31'b0, m_valid}, 32'd1);
                chk("b2b_m_regAddr", {27'b0, m_regAddr}, i);
            end
            tick();
        end
        idle_in();
        @(negedge clk);
        chk("b2b_m_valid3", {31'b0, m_valid}, 32'd1);
        chk("b2b_m_regAddr3", {27'b0, m_regAddr}, 32'd3);
        chk("b2b_m_regData3", m_regData, 32'h33);
        tick();
        @(negedge clk); chk("b2b_drained", {31'b0, m_valid}, 32'd0);

        // x0 destination suppresses the write enable.
        alu_op(5'd0, 32'h55);
        tick(); idle_in();
        @(negedge clk); chk("x0_m_regW", {31'b0, m_regW}, 32'd0);
        tick();

        do_store(32'h1003, 2'b00, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB, 2);
        do_store(32'h1002, 2'b01, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF, 1);
        do_store(32'h1000, 2'b10, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 1);

        do_load(32'h2002, 2'b01, 1'b0, 5'd7, 32'h8001_0000, 3, 32'hFFFF_8001);
        do_load(32'h2002, 2'b01, 1'b1, 5'd7, 32'h8001_0000, 3, 32'h0000_8001);
        do_load(32'h2001, 2'b00, 1'b0, 5'd8, 32'h0000_A500, 1, 32'hFFFF_FFA5);
        do_load(32'h2001, 2'b00, 1'b1, 5'd8, 32'h0000_A500, 2, 32'h0000_00A5);

        // Backpressure: result stalls, a waiting load must not be accepted.
        m_ready = 1'b0;
        alu_op(5'd9, 32'h99);
        @(negedge clk); chk("bp_e_ready0", {31'b0, e_ready}, 32'd1);
        tick();
        set_op(1'b1, 1'b0, 1'b1, 5'd10, 32'h4000, 2'b10, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_e_ready", {31'b0, e_ready}, 32'd0);
            chk("bp_mem_req", {31'b0, mem_req}, 32'd0);
            chk("bp_m_regData", m_regData, 32'h99);
            tick();
        end
        idle_in();
        m_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("bp_cleared", {31'b0, m_valid}, 32'd0);
        chk("bp_no_req", {31'b0, mem_req}, 32'd0);
        tick();

        // Reset while waiting for read data; the late rvalid must be ignored.
        set_op(1'b1, 1'b0, 1'b1, 5'd6, 32'h2000, 2'b10, 1'b0, 32'h0);
        tick(); idle_in();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        @(negedge clk); chk("rw_in_wait", {31'b0, e_ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("rw_e_ready", {31'b0, e_ready}, 32'd1);
        chk("rw_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rw_m_valid", {31'b0, m_valid}, 32'd0);
        tick();
        mem_rvalid = 1'b0; mem_gnt = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        chk("rw_m_valid_after", {31'b0, m_valid}, 32'd0);
        chk("rw_e_ready_after", {31'b0, e_ready}, 32'd1);
        tick();

`ifdef LSU_MISALIGN_CHECK_EN
        set_op(1'b1, 1'b0, 1'b1, 5'd4, 32'h3001, 2'b10, 1'b0, 32'h0);
        expq.push_back('{w: 1'b0, a: 5'd4, d: 32'h0, mis: 1'b1, chk_d: 1'b0});
        @(negedge clk); chk("mis_e_ready", {31'b0, e_ready}, 32'd1);
        tick(); idle_in();
        @(negedge clk);
        chk("mis_mem_req", {31'b0, mem_req}, 32'd0);
        chk("mis_m_valid", {31'b0, m_valid}, 32'd1);
        chk("mis_m_misalign", {31'b0, m_misalign}, 32'd1);
        chk("mis_m_regW", {31'b0, m_regW}, 32'd0);
        tick();
`else
        do_load(32'h3001, 2'b10, 1'b0, 5'd4, 32'h1234_5678, 1, 32'h1234_5678);
        chk("mis_addr_down", mem_addr, 32'h3000);
        chk("mis_flag_zero", {31'b0, m_misalign}, 32'd0);
`endif

        repeat (2) tick();
        chk("queue_drained", expq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, register-file address width.
REQ-002 Parameter DATA_WIDTH, default 32, datapath width; only 32 is supported.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port e_valid  input  1  execute stage presents an operation.
REQ-006 Port e_ready  output  1  lsu accepts the operation this cycle.
REQ-007 Port e_regW, e_regAddr, e_regData  input  1/ADDR_WIDTH/DATA_WIDTH  write enable, destination, ALU result (memory address for loads/stores).
REQ-008 Port e_memRd, e_memWr  input  1/1  load / store; never both set.
REQ-009 Port e_memSize  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-010 Port e_memUnsigned, e_storeData  input  1/DATA_WIDTH  load zero-extend flag; store source data.
REQ-011 Port mem_req, mem_we  output  1/1  bus request; write qualifier.
REQ-012 Port mem_addr, mem_wdata, mem_wmask  output  32/32/4  word-aligned address, lane-replicated data, byte mask.
REQ-013 Port mem_gnt, mem_rvalid, mem_rdata  input  1/1/32  grant, read-data valid, read data.
REQ-014 Port m_valid, m_ready  output/input  1/1  handshake to write-back stage.
REQ-015 Port m_regW, m_regAddr, m_regData  output  1/ADDR_WIDTH/DATA_WIDTH  write-back payload.
REQ-016 Port m_misalign  output  1  misaligned-access flag, valid with m_valid.

Function
REQ-017 FSM states SHALL be IDLE, REQ and WAIT.
REQ-018 e_ready SHALL be 1 only in IDLE and only when (!m_valid || m_ready).
REQ-019 On an accepted non-memory op, the payload SHALL appear registered on the m_* outputs the next cycle with m_valid=1 (latency 1), and the FSM SHALL stay in IDLE.
REQ-020 On an accepted load or store, the FSM SHALL go to REQ and hold mem_req=1 with stable mem_* outputs until mem_gnt=1.
REQ-021 A store SHALL complete on grant: REQ->IDLE, m_valid=1 next cycle, m_regW=0.
REQ-022 A load SHALL go REQ->WAIT on grant and WAIT->IDLE on mem_rvalid, with m_valid=1 the next cycle.
REQ-023 mem_rvalid SHALL be ignored outside WAIT, including when it coincides with mem_gnt.
REQ-024 mem_addr SHALL equal {e_regData[31:2],2'b00}; the offset SHALL be off=e_regData[1:0].
REQ-025 Store mask: byte 0001<<off, half 0011<<off, word 1111; mem_wdata: byte replicated x4, half replicated x2, word unchanged.
REQ-026 Load data SHALL be extracted from mem_rdata at byte lane off (half: lanes off, off+1) and then sign- or zero-extended per e_memUnsigned.
REQ-027 m_regW SHALL be forced to 0 when m_regAddr==0.
REQ-028 While m_valid && !m_ready, all m_* outputs SHALL be held unchanged.
REQ-029 m_valid SHALL clear after an m_ready handshake unless a new result is loaded in the same cycle.
REQ-030 Operation capture and result delivery in the same cycle SHALL be supported, sustaining 1 non-memory op per cycle.

Reset
REQ-031 When rst=1 at a rising edge, the block SHALL enter IDLE and clear m_valid, m_regW, m_regAddr, m_regData, m_misalign, mem_req, mem_we, mem_addr, mem_wdata and mem_wmask to 0.
REQ-032 Reset in REQ or WAIT SHALL abandon the transaction and ignore any later mem_gnt or mem_rvalid for it.

Configuration
REQ-033 Macro LSU_MISALIGN_CHECK_EN: when defined, a half access with off[0]=1 or a word access with off!=0 SHALL issue no bus request and SHALL complete in 1 cycle with m_misalign=1 and m_regW=0.
REQ-034 When LSU_MISALIGN_CHECK_EN is undefined, m_misalign SHALL be tied 0 and misaligned accesses SHALL use the aligned-down lanes without checking.

Verification
REQ-035 Test: 3 back-to-back ALU ops (regAddr 1,2,3; data 0x11,0x22,0x33), m_ready=1 -> m_valid for 3 consecutive cycles, in order, each 1 cycle after acceptance.
REQ-036 Test: store byte, addr 0x1003, data 0xAB -> mem_wmask=1000, mem_wdata=0xABABABAB, mem_addr=0x1000; with grant after 2 cycles, m_valid rises the cycle after grant with m_regW=0.
REQ-037 Test: load half signed, addr 0x2002, rdata 0x8001_0000, rvalid 3 cycles after grant -> m_regData=0xFFFF8001; with e_memUnsigned=1 -> 0x00008001.
REQ-038 Test: m_ready=0 for 4 cycles with a result pending -> m_* stable, e_ready=0, no new mem_req.
REQ-039 Test: rst asserted in WAIT, then rvalid -> no m_valid, FSM in IDLE, e_ready=1 the cycle after reset deasserts.
REQ-040 Test: with LSU_MISALIGN_CHECK_EN, load word at 0x3001 -> no mem_req, m_misalign=1, m_regW=0; without the macro -> bus read at 0x3000.
